// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM states and the GF(2^8) helpers used
// to build the forward S-box.
package aes_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 60;

  // Index 0 is never used; the first round constant is Rcon[1].
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    KS_LOAD,
    KS_EXPAND,
    KS_DONE
  } ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/key_expansion.sv
// AES key schedule for 128/192/256-bit keys: one load cycle, then one
// expanded word per clock into a 60-word register array.
module key_expansion
  import aes_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [255:0]                     key,
  input  logic [7:0]                       Nk,
  output logic [MAX_WORDS*WORD_W-1:0]      w,
  output logic                             doneFlag
);

  ks_state_t         state_reg;
  logic [3:0]        nk_reg;
  logic [5:0]        idx_reg;
  logic [3:0]        mod_reg;
  logic [3:0]        rcon_idx_reg;
  logic              done_reg;
  logic [WORD_W-1:0] words_reg [0:MAX_WORDS-1];

  logic [3:0]        nk_sel;
  logic [WORD_W-1:0] load_word [0:7];
  logic [WORD_W-1:0] prev_word;
  logic [WORD_W-1:0] back_word;
  logic [WORD_W-1:0] sub_in;
  logic [WORD_W-1:0] sub_word;
  logic [WORD_W-1:0] temp_word;
  logic [WORD_W-1:0] next_word;
  logic [5:0]        nw;
  logic              rot_phase;

  always_comb begin
    nk_sel = 4'd4;
    if (Nk == 8'd6)      nk_sel = 4'd6;
    else if (Nk == 8'd8) nk_sel = 4'd8;
  end

  // Key words are taken from the right-justified field; unused slots load 0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_load
    if (gi < 4) begin : g_all
      assign load_word[gi] = (nk_sel == 4'd8) ? key[255-32*gi -: 32] :
                             (nk_sel == 4'd6) ? key[191-32*gi -: 32] :
                                                key[127-32*gi -: 32];
    end else if (gi < 6) begin : g_mid
      assign load_word[gi] = (nk_sel == 4'd8) ? key[255-32*gi -: 32] :
                             (nk_sel == 4'd6) ? key[191-32*gi -: 32] : '0;
    end else begin : g_top
      assign load_word[gi] = (nk_sel == 4'd8) ? key[255-32*gi -: 32] : '0;
    end
  end

  assign nw        = {nk_reg, 2'b00} + 6'd28;
  assign rot_phase = (mod_reg == 4'd0);
  assign prev_word = words_reg[idx_reg - 6'd1];
  assign back_word = words_reg[idx_reg - {2'b00, nk_reg}];
  assign sub_in    = rot_phase ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*gi +: 8]),
      .out_byte (sub_word[8*gi +: 8])
    );
  end

  always_comb begin
    temp_word = prev_word;
    if (rot_phase)
      temp_word = sub_word ^ {RCON[rcon_idx_reg], 24'h000000};
    else if (nk_reg == 4'd8 && mod_reg == 4'd4)
      temp_word = sub_word;
    next_word = back_word ^ temp_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= KS_LOAD;
      nk_reg       <= 4'd0;
      idx_reg      <= 6'd0;
      mod_reg      <= 4'd0;
      rcon_idx_reg <= 4'd0;
      done_reg     <= 1'b0;
      for (int j = 0; j < MAX_WORDS; j++) words_reg[j] <= '0;
    end else begin
      case (state_reg)
        KS_LOAD: begin
          nk_reg       <= nk_sel;
          for (int j = 0; j < 8; j++) words_reg[j] <= load_word[j];
          idx_reg      <= {2'b00, nk_sel};
          mod_reg      <= 4'd0;
          rcon_idx_reg <= 4'd1;
          state_reg    <= KS_EXPAND;
        end
        KS_EXPAND: begin
          words_reg[idx_reg] <= next_word;
          idx_reg            <= idx_reg + 6'd1;
          mod_reg            <= (mod_reg == nk_reg - 4'd1) ? 4'd0 : mod_reg + 4'd1;
          if (rot_phase) rcon_idx_reg <= rcon_idx_reg + 4'd1;
          if (idx_reg == nw - 6'd1) begin
            state_reg <= KS_DONE;
            done_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_out
    assign w[MAX_WORDS*WORD_W-1-WORD_W*gi -: WORD_W] = words_reg[gi];
  end
  assign doneFlag = done_reg;

endmodule

// File: tb/tb_key_expansion.sv
// Directed-vector bench for key_expansion using FIPS-197 key schedules.
module tb_key_expansion;

  logic          clk;
  logic          reset;
  logic [255:0]  key;
  logic [7:0]    Nk;
  logic [1919:0] w;
  logic          doneFlag;

  int n_vec;
  int n_bad;

  localparam logic [255:0] K128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [255:0] K192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expansion dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .Nk       (Nk),
    .w        (w),
    .doneFlag (doneFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int i);
    return w[1919-32*i -: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Reset, release, then count clocks until doneFlag. Optionally disturb key/Nk after the load edge.
  task automatic run_schedule(input string tag, input logic [255:0] k, input logic [7:0] n,
                              input int exp_cycles, input bit scramble);
    int cnt;
    key   = k;
    Nk    = n;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_w"},    {31'b0, |w},      32'h0);
    check({tag, "_rst_done"}, {31'b0, doneFlag}, 32'h0);
    reset = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      if (scramble && cnt == 1) begin
        key = '1;
        Nk  = 8'd8;
      end
      if (doneFlag) break;
    end
    check({tag, "_cycles"}, 32'(cnt), 32'(exp_cycles));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    key   = '0;
    Nk    = 8'd4;

    run_schedule("aes128", K128, 8'd4, 41, 1'b0);
    check("aes128_w0",  word(0),  32'h2b7e1516);
    check("aes128_w4",  word(4),  32'ha0fafe17);
    check("aes128_w43", word(43), 32'hb6630ca6);
    for (int i = 44; i < 60; i++) check($sformatf("aes128_w%0d", i), word(i), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("aes128_hold_done", {31'b0, doneFlag}, 32'h1);
    check("aes128_hold_w43",  word(43), 32'hb6630ca6);

    run_schedule("aes192", K192, 8'd6, 47, 1'b0);
    check("aes192_w6",  word(6),  32'hfe0c91f7);
    check("aes192_w51", word(51), 32'h01002202);
    check("aes192_w52", word(52), 32'h0);

    run_schedule("aes256", K256, 8'd8, 53, 1'b0);
    check("aes256_w8",  word(8),  32'h9ba35411);
    check("aes256_w12", word(12), 32'ha8b09c1a);
    check("aes256_w59", word(59), 32'h706c631e);

    // Abort an AES-256 run at clock 20, then finish an AES-128 run.
    key   = K256;
    Nk    = 8'd8;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_w8",   word(8), 32'h9ba35411);
    check("mid_done", {31'b0, doneFlag}, 32'h0);
    check("mid_w40",  word(40), 32'h0);
    reset = 1'b0;
    #1;
    check("abort_w",    {31'b0, |w},      32'h0);
    check("abort_done", {31'b0, doneFlag}, 32'h0);
    run_schedule("after_abort", K128, 8'd4, 41, 1'b0);
    check("after_abort_w4",  word(4),  32'ha0fafe17);
    check("after_abort_w43", word(43), 32'hb6630ca6);

    run_schedule("scramble", K128, 8'd4, 41, 1'b1);
    check("scramble_w4",  word(4),  32'ha0fafe17);
    check("scramble_w43", word(43), 32'hb6630ca6);
    check("scramble_w44", word(44), 32'h0);

    run_schedule("nk5", {128'hdeadbeef_01234567_89abcdef_fedcba98, K128[127:0]}, 8'd5, 41, 1'b0);
    check("nk5_w0",  word(0),  32'h2b7e1516);
    check("nk5_w4",  word(4),  32'ha0fafe17);
    check("nk5_w43", word(43), 32'hb6630ca6);
    check("nk5_w44", word(44), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: KeyExpansion

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the single clock of the block.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: key  input  256  cipher key, right-justified: the Nk*32-bit key sits in key[Nk*32-1:0]; the MSB word of that field is key word 0; upper bits are ignored.
REQ-004 SHALL have port: Nk  input  8  key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
REQ-005 SHALL have port: w  output  1920  expanded key schedule, 60 words; word i at w[1919-32*i -: 32] (word 0 in the MSBs); words beyond the schedule length read 0.
REQ-006 SHALL have port: doneFlag  output  1  high when the full schedule in w is valid.

Function
REQ-007 SHALL derive Nr = Nk+6 and total word count Nw = 4*(Nr+1): 44, 52 or 60.
REQ-008 SHALL treat any Nk value other than 6 or 8 as Nk=4.
REQ-009 SHALL, on the first rising clk with reset high, latch Nk and load words 0..Nk-1 from key in one cycle, setting the word index i to Nk.
REQ-010 SHALL ignore key and Nk after that load cycle until the next reset.
REQ-011 SHALL then compute exactly one word per clock, w[i] = w[i-Nk] XOR temp, with temp = w[i-1], then increment i.
REQ-012 SHALL, when i mod Nk == 0, use temp = SubWord(RotWord(w[i-1])) XOR {Rcon[i/Nk], 24'h0}.
REQ-013 SHALL, when Nk==8 and i mod 8 == 4, use temp = SubWord(w[i-1]).
REQ-014 SHALL define RotWord as a 1-byte left rotation ({a0,a1,a2,a3} -> {a1,a2,a3,a0}) and SubWord as the AES forward S-box applied to each byte.
REQ-015 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-016 SHALL stop computing when i reaches Nw, then assert doneFlag on the same edge that writes word Nw-1, and hold w and doneFlag stable until reset.
REQ-017 SHALL therefore assert doneFlag after 1+Nw-Nk clocks following reset release: 41 (Nk=4), 47 (Nk=6), 53 (Nk=8).
REQ-018 SHALL keep doneFlag low and words not yet written at 0 during expansion.

Reset
REQ-019 SHALL, while reset is low, asynchronously clear w to all zeros, doneFlag to 0, the word index to 0 and the latched Nk.
REQ-020 SHALL abort any in-progress expansion when reset is asserted mid-operation and restart from the load cycle after release.

Structure
REQ-021 SHALL place the Rcon table, the maximum word count (60) and the word width (32) in a shared AES package.
REQ-022 SHALL instantiate a sub-module aes_sbox (8-bit combinational forward S-box), used four times to form SubWord.
REQ-023 SHALL store the schedule in a 60x32 register array and share a single SubWord datapath for both REQ-012 and REQ-013.

Verification
REQ-024 SHALL verify AES-128: key=2b7e151628aed2a6abf7158809cf4f3c, Nk=4 -> w word 4 = a0fafe17, word 43 = b6630ca6, doneFlag high 41 clocks after release, words 44..59 = 0.
REQ-025 SHALL verify AES-192: key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, Nk=6 -> word 6 = fe0c91f7, word 51 = 01002202, doneFlag high after 47 clocks.
REQ-026 SHALL verify AES-256: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, Nk=8 -> word 8 = 9ba35411, word 12 = a8b09c1a (SubWord-only path), word 59 = 706c631e, doneFlag after 53 clocks.
REQ-027 SHALL verify reset mid-expansion: drop reset at clock 20 of an AES-256 run -> w=0 and doneFlag=0 immediately; after release, an AES-128 run completes with correct values.
REQ-028 SHALL verify that changing key after the load cycle does not alter w, and that Nk=5 produces the AES-128 schedule of key[127:0].
